// File: rtl/imm_extend_unit.sv
// Registered immediate generator: accumulates prefix chunks, sign/zero-extends to DATA_W.
// Optional IMM_SHIFT_MODE_EN macro enables the mode[1] left shift by SHIFT_AMT.
module imm_extend_unit #(
    parameter int IMM_W      = 11,
    parameter int DATA_W     = 64,
    parameter int MAX_PREFIX = 5,
    parameter int SHIFT_AMT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic              prefix,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              err
);

    localparam int ACC_W  = MAX_PREFIX * IMM_W;
    localparam int FULL_W = (MAX_PREFIX + 1) * IMM_W;
    localparam int CW     = $clog2(MAX_PREFIX + 1);

    logic [ACC_W-1:0]  acc;
    logic [CW-1:0]     cnt;
    logic [ACC_W-1:0]  acc_eff;
    logic [CW-1:0]     cnt_eff;
    logic [FULL_W-1:0] full;
    logic              accept;
    logic              ext_bit;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] ext_res;
    logic [DATA_W-1:0] result;

    logic [MAX_PREFIX:0] sign_at;
    logic [DATA_W-1:0]   mask_at [MAX_PREFIX+1];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A same-cycle flush empties the accumulator before the beat is looked at.
    assign acc_eff = flush ? '0 : acc;
    assign cnt_eff = flush ? '0 : cnt;
    assign full    = {acc_eff, imm};

    // Per prefix count: the sign bit of the assembled value and the valid-bit mask.
    for (genvar g = 0; g <= MAX_PREFIX; g++) begin : g_width
        if ((g + 1) * IMM_W >= DATA_W) begin : g_wide
            assign sign_at[g] = 1'b0;
            assign mask_at[g] = '1;
        end else begin : g_narrow
            assign sign_at[g] = full[(g + 1) * IMM_W - 1];
            assign mask_at[g] = {{(DATA_W - (g + 1) * IMM_W){1'b0}}, {((g + 1) * IMM_W){1'b1}}};
        end
    end

    if (FULL_W > DATA_W) begin : g_unused_hi
        logic unused_full_hi;
        assign unused_full_hi = ^full[FULL_W-1:DATA_W];
    end

    always_comb begin
        mask    = mask_at[cnt_eff];
        ext_bit = !mode[0] && sign_at[cnt_eff];
        ext_res = (full[DATA_W-1:0] & mask) | (ext_bit ? ~mask : '0);
`ifdef IMM_SHIFT_MODE_EN
        result  = mode[1] ? (ext_res << SHIFT_AMT) : ext_res;
`else
        result  = ext_res;
`endif
    end

`ifndef IMM_SHIFT_MODE_EN
    logic unused_mode1;
    assign unused_mode1 = mode[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (flush) begin
                acc <= '0;
                cnt <= '0;
            end
            if (accept) begin
                if (prefix) begin
                    if (cnt_eff < CW'(MAX_PREFIX)) begin
                        acc <= full[ACC_W-1:0];
                        cnt <= cnt_eff + CW'(1);
                    end else begin
                        err <= 1'b1;
                    end
                    if (out_ready) out_valid <= 1'b0;
                end else begin
                    out       <= result;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed self-checking bench for imm_extend_unit with hand-computed expected values.
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] imm;
    logic        prefix;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
    logic        err;

    int errors = 0;
    int checks = 0;

    imm_extend_unit #(.IMM_W(11), .DATA_W(64), .MAX_PREFIX(5), .SHIFT_AMT(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .prefix(prefix), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic p, input logic [10:0] v, input logic [1:0] m);
        in_valid = 1'b1;
        prefix   = p;
        imm      = v;
        mode     = m;
        step();
        in_valid = 1'b0;
        prefix   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; imm = '0;
        prefix = 1'b0; mode = 2'b00; out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", out, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        send(1'b0, 11'h7FF, 2'b00);
        check("sign_single_valid", 64'(out_valid), 64'd1);
        check("sign_single", out, 64'hFFFF_FFFF_FFFF_FFFF);
        send(1'b0, 11'h3FF, 2'b00);
        check("sign_positive", out, 64'h0000_0000_0000_03FF);
        send(1'b0, 11'h7FF, 2'b01);
        check("zero_single", out, 64'h0000_0000_0000_07FF);

        send(1'b1, 11'h400, 2'b00);
        check("prefix_no_output", 64'(out_valid), 64'd0);
        send(1'b0, 11'h003, 2'b00);
        check("prefix_sign", out, 64'hFFFF_FFFF_FFE0_0003);
        send(1'b1, 11'h400, 2'b01);
        send(1'b0, 11'h003, 2'b01);
        check("prefix_zero", out, 64'h0000_0000_0020_0003);

        send(1'b1, 11'h400, 2'b00);
        flush = 1'b1; step(); flush = 1'b0;
        send(1'b0, 11'h003, 2'b00);
        check("flush_between", out, 64'h3);
        send(1'b1, 11'h001, 2'b00);
        flush = 1'b1;
        send(1'b0, 11'h002, 2'b00);
        flush = 1'b0;
        check("flush_same_cycle", out, 64'h2);

        step();
        check("drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        send(1'b0, 11'h001, 2'b00);
        check("bp_first_out", out, 64'h1);
        in_valid = 1'b1; imm = 11'h002; prefix = 1'b0; mode = 2'b00;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        step();
        check("bp_held_out", out, 64'h1);
        check("bp_held_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_second_out", out, 64'h2);
        check("bp_second_valid", 64'(out_valid), 64'd1);
        step();
        check("bp_consumed", 64'(out_valid), 64'd0);
        check("bp_out_holds", out, 64'h2);

        for (int i = 0; i < 5; i++) send(1'b1, 11'h001, 2'b00);
        check("ovf_err_before", 64'(err), 64'd0);
        send(1'b1, 11'h001, 2'b00);
        check("ovf_err_set", 64'(err), 64'd1);
        send(1'b0, 11'h000, 2'b00);
        check("ovf_assembled", out, 64'h0080_1002_0040_0800);
        send(1'b0, 11'h005, 2'b00);
        check("ovf_cnt_cleared", out, 64'h5);
        check("ovf_err_sticky", 64'(err), 64'd1);

        send(1'b0, 11'h7FF, 2'b10);
`ifdef IMM_SHIFT_MODE_EN
        check("shift_sign", out, 64'hFFFF_FFFF_FFFF_FFFC);
`else
        check("shift_sign", out, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        send(1'b0, 11'h7FF, 2'b11);
`ifdef IMM_SHIFT_MODE_EN
        check("shift_zero", out, 64'h0000_0000_0000_1FFC);
`else
        check("shift_zero", out, 64'h0000_0000_0000_07FF);
`endif

        send(1'b1, 11'h001, 2'b00);
        reset = 1'b1; step(); reset = 1'b0;
        check("rst2_err", 64'(err), 64'd0);
        check("rst2_valid", 64'(out_valid), 64'd0);
        check("rst2_out", out, 64'd0);
        send(1'b0, 11'h003, 2'b00);
        check("rst2_prefix_dropped", out, 64'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
